// File: rtl/plru_pkg.sv
// plru_pkg: shared types and tree helpers for the tree pseudo-LRU replacer.
// Node vectors are sized for the largest supported tree; users slice to their own width.
package plru_pkg;
    localparam int PLRU_MAX_WAY = 32;
    localparam int PLRU_MAX_LVL = 5;
    typedef logic [PLRU_MAX_WAY-2:0] plru_node_t;
    typedef enum logic {PLRU_SWEEP, PLRU_IDLE} plru_state_e;
    function automatic logic plru_path_bit(input int level, input int levels, input int way);
        return 1'((way >> (levels - 1 - level)) & 1);
    endfunction
    // Every node on the way's root-to-leaf path is pointed away from that way
    function automatic plru_node_t plru_touch(input plru_node_t node, input int levels, input int way);
        int n;
        logic b;
        n = 0;
        for (int l = 0; l < PLRU_MAX_LVL; l++)
            if (l < levels) begin
                b = plru_path_bit(l, levels, way);
                node[n] = ~b;
                n = 2 * n + 1 + int'(b);
            end
        return node;
    endfunction
endpackage

// File: rtl/tree_plru_replacer_if.sv
// tree_plru_replacer_if: touch, flush and victim-lookup signals of the PLRU replacer.
interface tree_plru_replacer_if #(
    parameter int DEPTH      = 64,
    parameter int WAY_NUM    = 8,
    parameter int HIT_PORT   = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int WAY_WIDTH  = $clog2(WAY_NUM)
);
    logic                                flush_req;
    logic                                busy;
    logic [HIT_PORT-1:0]                 hit_en;
    logic [HIT_PORT-1:0][ADDR_WIDTH-1:0] hit_index;
    logic [HIT_PORT-1:0][WAY_WIDTH-1:0]  hit_way;
    logic                                fill_en;
    logic [ADDR_WIDTH-1:0]               fill_index;
    logic [WAY_WIDTH-1:0]                fill_way;
    logic                                miss_req;
    logic                                miss_rdy;
    logic [ADDR_WIDTH-1:0]               miss_index;
    logic [WAY_NUM-1:0]                  miss_valid;
    logic [WAY_NUM-1:0]                  miss_lock;
    logic                                resp_valid;
    logic [WAY_WIDTH-1:0]                resp_way;
    logic                                resp_none;
    modport master (
        output flush_req, hit_en, hit_index, hit_way, fill_en, fill_index, fill_way,
               miss_req, miss_index, miss_valid, miss_lock,
        input  busy, miss_rdy, resp_valid, resp_way, resp_none
    );
    modport slave (
        input  flush_req, hit_en, hit_index, hit_way, fill_en, fill_index, fill_way,
               miss_req, miss_index, miss_valid, miss_lock,
        output busy, miss_rdy, resp_valid, resp_way, resp_none
    );
endinterface

// File: rtl/plru_tree_select.sv
// plru_tree_select: combinational victim choice, invalid unlocked ways first,
// otherwise a tree walk that steers around fully locked subtrees.
module plru_tree_select #(
    parameter int WAY_NUM   = 8,
    parameter int WAY_WIDTH = $clog2(WAY_NUM),
    parameter int NODE_NUM  = WAY_NUM - 1
) (
    input  logic [NODE_NUM-1:0]  tree_i,
    input  logic [WAY_NUM-1:0]   valid_i,
    input  logic [WAY_NUM-1:0]   lock_i,
    output logic [WAY_WIDTH-1:0] way_o,
    output logic                 none_o
);
    logic [2*WAY_NUM-2:0] avail;
    logic [WAY_WIDTH-1:0] walk_way;
    logic [WAY_WIDTH-1:0] free_way;
    logic                 free_hit;
    // Heap over nodes and leaves (leaf of way w at NODE_NUM+w): 1 if any unlocked way below
    function automatic logic [2*WAY_NUM-2:0] subtree_avail(input logic [WAY_NUM-1:0] lock);
        logic [2*WAY_NUM-2:0] a;
        a = '0;
        for (int w = 0; w < WAY_NUM; w++) a[NODE_NUM + w] = ~lock[w];
        for (int n = NODE_NUM - 1; n >= 0; n--) a[n] = a[2*n+1] | a[2*n+2];
        return a;
    endfunction
    function automatic logic [WAY_WIDTH-1:0] walk(input logic [NODE_NUM-1:0] tree, input logic [2*WAY_NUM-2:0] av);
        int n;
        logic go;
        n = 0;
        for (int l = 0; l < WAY_WIDTH; l++) begin
            go = tree[n];
            if (!av[2*n + 1 + int'(go)]) go = ~go;
            n = 2*n + 1 + int'(go);
        end
        return WAY_WIDTH'(n - NODE_NUM);
    endfunction
    assign avail    = subtree_avail(lock_i);
    assign walk_way = walk(tree_i, avail);
    always_comb begin
        free_hit = 1'b0;
        free_way = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--)
            if (!valid_i[w] && !lock_i[w]) begin
                free_hit = 1'b1;
                free_way = WAY_WIDTH'(w);
            end
    end
    assign none_o = ~avail[0];
    assign way_o  = none_o ? '0 : free_hit ? free_way : walk_way;
endmodule

// File: rtl/tree_plru_replacer.sv
// tree_plru_replacer: per-set PLRU tree array with a one-set-per-cycle clearing sweep,
// ordered same-set touch composition and a registered victim lookup.
module tree_plru_replacer
    import plru_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int WAY_NUM    = 8,
    parameter int HIT_PORT   = 2,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int WAY_WIDTH  = $clog2(WAY_NUM),
    parameter int NODE_NUM   = WAY_NUM - 1
) (
    input logic                 clk,
    input logic                 rst,
    tree_plru_replacer_if.slave bus
);
    localparam int TOUCH_NUM = HIT_PORT + 1;
    plru_state_e                         state_q;
    logic [ADDR_WIDTH-1:0]               cnt_q;
    logic [NODE_NUM-1:0]                 tree_q [DEPTH];
    logic                                idle;
    logic                                accept;
    logic [TOUCH_NUM-1:0]                t_en;
    logic [TOUCH_NUM-1:0][ADDR_WIDTH-1:0] t_idx;
    logic [TOUCH_NUM-1:0][WAY_WIDTH-1:0]  t_way;
    logic [NODE_NUM-1:0]                 t_new [TOUCH_NUM];
    logic [WAY_WIDTH-1:0]                sel_way;
    logic                                sel_none;
    logic                                resp_valid_q;
    logic [WAY_WIDTH-1:0]                resp_way_q;
    logic                                resp_none_q;
    function automatic logic [NODE_NUM-1:0] compose(input logic [NODE_NUM-1:0] base,
            input logic [TOUCH_NUM-1:0] sel, input logic [TOUCH_NUM-1:0][WAY_WIDTH-1:0] ways);
        plru_node_t n;
        n = plru_node_t'(base);
        for (int j = 0; j < TOUCH_NUM; j++)
            if (sel[j]) n = plru_touch(n, WAY_WIDTH, int'(ways[j]));
        return NODE_NUM'(n);
    endfunction
    assign idle   = state_q == PLRU_IDLE;
    assign accept = bus.miss_req & idle;
    assign t_en   = {bus.fill_en, bus.hit_en} & {TOUCH_NUM{idle}};
    assign t_idx  = {bus.fill_index, bus.hit_index};
    assign t_way  = {bus.fill_way, bus.hit_way};
    // Slot k folds in every earlier same-set touch, so the last enabled slot of a set is the full result
    for (genvar k = 0; k < TOUCH_NUM; k++) begin : g_touch
        logic [TOUCH_NUM-1:0] same;
        for (genvar j = 0; j < TOUCH_NUM; j++) begin : g_same
            assign same[j] = j <= k && t_en[j] && t_idx[j] == t_idx[k];
        end
        assign t_new[k] = compose(tree_q[t_idx[k]], same, t_way);
    end
    always_ff @(posedge clk)
        if (!idle) tree_q[cnt_q] <= '0;
        else for (int k = 0; k < TOUCH_NUM; k++) if (t_en[k]) tree_q[t_idx[k]] <= t_new[k];
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= PLRU_SWEEP;
            cnt_q   <= '0;
        end else if (!idle) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_q <= PLRU_IDLE;
        end else if (bus.flush_req) begin
            state_q <= PLRU_SWEEP;
            cnt_q   <= '0;
        end
    plru_tree_select #(.WAY_NUM(WAY_NUM)) u_select (
        .tree_i  (tree_q[bus.miss_index]),
        .valid_i (bus.miss_valid),
        .lock_i  (bus.miss_lock),
        .way_o   (sel_way),
        .none_o  (sel_none)
    );
    always_ff @(posedge clk)
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_way_q   <= '0;
            resp_none_q  <= 1'b0;
        end else begin
            resp_valid_q <= accept;
            if (accept) begin
                resp_way_q  <= sel_way;
                resp_none_q <= sel_none;
            end
        end
    assign bus.busy       = ~idle;
    assign bus.miss_rdy   = idle;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_way   = resp_way_q;
    assign bus.resp_none  = resp_none_q;
endmodule

// File: tb/tb_tree_plru_replacer.sv
// tb_tree_plru_replacer: directed vectors on a 4-way and an 8-way replacer sharing clk/rst.
module tb_tree_plru_replacer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    tree_plru_replacer_if #(.WAY_NUM(4)) if4 ();
    tree_plru_replacer_if #(.WAY_NUM(8)) if8 ();
    tree_plru_replacer #(.WAY_NUM(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    tree_plru_replacer #(.WAY_NUM(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    typedef struct {
        int hen, hidx0, hway0, hidx1, hway1, fen, fway;
        int req, midx, valid, lock;
        int ev, ew, en;
    } vec_t;
    vec_t tbl [16];
    int total = 0;
    int passed = 0;
    task automatic check(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic clear4;
        if4.flush_req = 0; if4.hit_en = '0; if4.hit_index = '0; if4.hit_way = '0;
        if4.fill_en = 0; if4.fill_index = '0; if4.fill_way = '0;
        if4.miss_req = 0; if4.miss_index = '0; if4.miss_valid = '1; if4.miss_lock = '0;
    endtask
    task automatic clear8;
        if8.flush_req = 0; if8.hit_en = '0; if8.hit_index = '0; if8.hit_way = '0;
        if8.fill_en = 0; if8.fill_index = '0; if8.fill_way = '0;
        if8.miss_req = 0; if8.miss_index = '0; if8.miss_valid = '1; if8.miss_lock = '0;
    endtask
    initial begin
        int n;
        int stray;
        int lk [6] = '{'h00, 'h0C, 'h0F, 'h4F, 'hFF, 'h00};
        int mi [6] = '{3, 3, 3, 3, 3, 4};
        int ew [6] = '{2, 1, 6, 7, 0, 0};
        // hen hidx0 hway0 hidx1 hway1 fen fway | req midx valid lock | ev ew en
        tbl = '{
            '{0, 0, 0, 0, 0, 0, 0, 1, 5, 'hF, 'h0, 1, 0, 0},
            '{1, 5, 0, 0, 0, 0, 0, 0, 5, 'hF, 'h0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 1, 5, 'hF, 'h0, 1, 2, 0},
            '{1, 5, 2, 0, 0, 0, 0, 0, 5, 'hF, 'h0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 1, 5, 'hF, 'h0, 1, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 1, 5, 'hB, 'h0, 1, 2, 0},
            '{1, 5, 1, 0, 0, 1, 2, 0, 5, 'hF, 'h0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 1, 5, 'hF, 'h5, 1, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 1, 5, 'hF, 'hF, 1, 0, 1},
            '{0, 0, 0, 0, 0, 0, 0, 1, 5, 'hF, 'h3, 1, 3, 0},
            '{0, 0, 0, 0, 0, 0, 0, 1, 5, 'h0, 'h1, 1, 1, 0},
            '{1, 5, 0, 0, 0, 0, 0, 1, 5, 'hF, 'h0, 1, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 1, 5, 'hF, 'h0, 1, 3, 0},
            '{3, 6, 0, 5, 2, 0, 0, 0, 5, 'hF, 'h0, 0, 0, 0},
            '{0, 0, 0, 0, 0, 0, 0, 1, 5, 'hF, 'h0, 1, 1, 0},
            '{0, 0, 0, 0, 0, 0, 0, 1, 6, 'hF, 'h0, 1, 2, 0}
        };
        rst = 1;
        clear4();
        clear8();
        tick;
        check("rst_busy", 32'(if4.busy), 1);
        check("rst_miss_rdy", 32'(if4.miss_rdy), 0);
        check("rst_resp_valid", 32'(if4.resp_valid), 0);
        check("rst_resp_way", 32'(if4.resp_way), 0);
        check("rst_resp_none", 32'(if4.resp_none), 0);
        rst = 0;
        n = 0;
        while (if4.busy && n < 200) begin
            n++;
            tick;
        end
        check("reset_sweep_len", n, 64);
        check("reset_sweep_len_w8", 32'(if8.busy), 0);
        foreach (tbl[i]) begin
            if4.hit_en       = 2'(tbl[i].hen);
            if4.hit_index[0] = 6'(tbl[i].hidx0);
            if4.hit_way[0]   = 2'(tbl[i].hway0);
            if4.hit_index[1] = 6'(tbl[i].hidx1);
            if4.hit_way[1]   = 2'(tbl[i].hway1);
            if4.fill_en      = 1'(tbl[i].fen);
            if4.fill_index   = 6'd5;
            if4.fill_way     = 2'(tbl[i].fway);
            if4.miss_req     = 1'(tbl[i].req);
            if4.miss_index   = 6'(tbl[i].midx);
            if4.miss_valid   = 4'(tbl[i].valid);
            if4.miss_lock    = 4'(tbl[i].lock);
            tick;
            check($sformatf("vec%0d_resp_valid", i), 32'(if4.resp_valid), tbl[i].ev);
            if (tbl[i].ev != 0) begin
                check($sformatf("vec%0d_resp_way", i), 32'(if4.resp_way), tbl[i].ew);
                check($sformatf("vec%0d_resp_none", i), 32'(if4.resp_none), tbl[i].en);
            end
        end
        clear4();
        // Same-set conflict on the 8-way tree: port0 way0, port1 way7, fill way4
        if8.hit_en = 2'b11;
        if8.hit_index[0] = 6'd3; if8.hit_way[0] = 3'd0;
        if8.hit_index[1] = 6'd3; if8.hit_way[1] = 3'd7;
        if8.fill_en = 1; if8.fill_index = 6'd3; if8.fill_way = 3'd4;
        tick;
        check("conflict_no_resp", 32'(if8.resp_valid), 0);
        clear8();
        for (int i = 0; i < 6; i++) begin
            if8.miss_req = 1;
            if8.miss_index = 6'(mi[i]);
            if8.miss_valid = 8'hFF;
            if8.miss_lock = 8'(lk[i]);
            tick;
            check($sformatf("conflict%0d_resp_valid", i), 32'(if8.resp_valid), 1);
            check($sformatf("conflict%0d_resp_way", i), 32'(if8.resp_way), ew[i]);
            check($sformatf("conflict%0d_resp_none", i), 32'(if8.resp_none), lk[i] == 'hFF ? 1 : 0);
        end
        clear8();
        // Flush with traffic: hits during the sweep must be dropped, lookup held off
        if4.hit_en = 2'b01; if4.hit_index[0] = 6'd5; if4.hit_way[0] = 2'd0;
        if4.flush_req = 1;
        tick;
        check("flush_busy_next", 32'(if4.busy), 1);
        if4.flush_req = 0;
        if4.miss_req = 1; if4.miss_index = 6'd5; if4.miss_valid = 4'hF; if4.miss_lock = 4'h0;
        n = 0;
        stray = 0;
        while (!if4.miss_rdy && n < 200) begin
            if (if4.resp_valid) stray++;
            if4.flush_req = n == 10;
            n++;
            tick;
        end
        if4.hit_en = '0;
        if4.flush_req = 0;
        check("flush_sweep_len", n, 64);
        check("flush_no_resp_during_sweep", stray, 0);
        tick;
        if4.miss_req = 0;
        check("post_flush_resp_valid", 32'(if4.resp_valid), 1);
        check("post_flush_resp_way", 32'(if4.resp_way), 0);
        tick;
        check("resp_pulse_one_cycle", 32'(if4.resp_valid), 0);
        // Reset in the middle of a sweep restarts the full count
        if4.flush_req = 1;
        tick;
        if4.flush_req = 0;
        repeat (20) tick;
        check("mid_sweep_busy", 32'(if4.busy), 1);
        rst = 1;
        tick;
        rst = 0;
        n = 0;
        while (if4.busy && n < 200) begin
            n++;
            tick;
        end
        check("rst_mid_sweep_len", n, 64);
        if4.miss_req = 1; if4.miss_index = 6'd6; if4.miss_valid = 4'hF; if4.miss_lock = 4'h0;
        tick;
        if4.miss_req = 0;
        check("post_rst_resp_way", 32'(if4.resp_way), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
